// File: rtl/tx_dma_chan_ctrl_pkg.sv
// tx_dma_chan_ctrl_pkg: shared state encoding, register offsets and STATUS layout
package tx_dma_chan_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STOPPING = 2'd2
  } chan_state_t;
  localparam logic [3:0] REG_CONTROL = 4'h0;
  localparam logic [3:0] REG_STATUS  = 4'h4;
  localparam logic [3:0] REG_PENDING = 4'h8;
  localparam logic [3:0] REG_DROPS   = 4'hC;
  localparam int ST_STATE_LSB = 0;
  localparam int ST_TOUT_BIT  = 2;
  localparam int ST_UNF_BIT   = 3;
endpackage

// File: rtl/tx_dma_chan_ctrl_if.sv
// tx_dma_chan_ctrl_if: MI configuration bus between software master and the controller
interface tx_dma_chan_ctrl_if #(
  parameter int MI_WIDTH = 32
);
  logic [MI_WIDTH-1:0]   MI_ADDR;
  logic [MI_WIDTH-1:0]   MI_DWR;
  logic [MI_WIDTH/8-1:0] MI_BE;
  logic                  MI_RD;
  logic                  MI_WR;
  logic [MI_WIDTH-1:0]   MI_DRD;
  logic                  MI_ARDY;
  logic                  MI_DRDY;
  modport master (output MI_ADDR, MI_DWR, MI_BE, MI_RD, MI_WR, input MI_DRD, MI_ARDY, MI_DRDY);
  modport slave  (input MI_ADDR, MI_DWR, MI_BE, MI_RD, MI_WR, output MI_DRD, MI_ARDY, MI_DRDY);
endinterface

// File: rtl/tx_dma_chan_ctrl_fsm.sv
// tx_dma_chan_ctrl_fsm: one channel's start/stop FSM, in-flight counter, stop timer, flags and drops
module tx_dma_chan_ctrl_fsm
  import tx_dma_chan_ctrl_pkg::*;
#(
  parameter int PEND_WIDTH   = 10,
  parameter int CNTRS_WIDTH  = 32,
  parameter int STOP_TIMEOUT = 65535
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   ctrl_wr_i,
  input  logic                   wr_bit_i,
  input  logic                   drops_clr_i,
  input  logic                   acc_i,
  input  logic                   done_i,
  output chan_state_t            state_o,
  output logic                   ctrl_o,
  output logic                   tout_o,
  output logic                   unf_o,
  output logic [PEND_WIDTH-1:0]  pend_o,
  output logic [CNTRS_WIDTH-1:0] drops_o
);
  localparam int TW = $clog2(STOP_TIMEOUT + 1);
  chan_state_t            state_q;
  logic                   ctrl_q, tout_q, unf_q;
  logic [TW-1:0]          timer_q;
  logic [PEND_WIDTH-1:0]  pend_q;
  logic [CNTRS_WIDTH-1:0] drops_q;
  logic running, start, stop, force_stop, acc_ok, underflow;
  assign running    = state_q == ST_RUNNING;
  assign start      = ctrl_wr_i && wr_bit_i && !ctrl_q;
  assign stop       = ctrl_wr_i && !wr_bit_i && ctrl_q;
  assign force_stop = state_q == ST_STOPPING && !start && pend_q != '0 && timer_q == TW'(1);
  assign acc_ok     = acc_i && running;
  assign underflow  = done_i && !acc_ok && pend_q == '0;
  // channel state machine: start/stop requests, drain detection and stop timeout
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= ST_STOPPED;
      ctrl_q  <= 1'b0;
      tout_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      if (ctrl_wr_i) ctrl_q <= wr_bit_i;
      if (start) begin
        state_q <= ST_RUNNING;
        if (state_q == ST_STOPPED) tout_q <= 1'b0;
      end else if (stop) begin
        state_q <= ST_STOPPING;
        timer_q <= TW'(STOP_TIMEOUT);
      end else if (state_q == ST_STOPPING) begin
        if (pend_q == '0) state_q <= ST_STOPPED;
        else if (force_stop) begin
          state_q <= ST_STOPPED;
          tout_q  <= 1'b1;
        end else timer_q <= timer_q - TW'(1);
      end
    end
  // in-flight packet counter, underflow flag and saturating drop counter
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      pend_q  <= '0;
      unf_q   <= 1'b0;
      drops_q <= '0;
    end else begin
      if (force_stop) pend_q <= '0;
      else if (acc_ok && !done_i && pend_q != '1) pend_q <= pend_q + PEND_WIDTH'(1);
      else if (done_i && !acc_ok && pend_q != '0) pend_q <= pend_q - PEND_WIDTH'(1);
      if (underflow) unf_q <= 1'b1;
      else if (start && state_q == ST_STOPPED) unf_q <= 1'b0;
      if (drops_clr_i) drops_q <= '0;
      else if (acc_i && !running && drops_q != '1) drops_q <= drops_q + CNTRS_WIDTH'(1);
    end
  assign state_o = state_q;
  assign ctrl_o  = ctrl_q;
  assign tout_o  = tout_q;
  assign unf_o   = unf_q;
  assign pend_o  = pend_q;
  assign drops_o = drops_q;
endmodule

// File: rtl/tx_dma_chan_ctrl.sv
// tx_dma_chan_ctrl: MI register decode and read mux over per-channel start/stop controllers
module tx_dma_chan_ctrl
  import tx_dma_chan_ctrl_pkg::*;
#(
  parameter int CHANNELS     = 8,
  parameter int MI_WIDTH     = 32,
  parameter int PEND_WIDTH   = 10,
  parameter int CNTRS_WIDTH  = 32,
  parameter int STOP_TIMEOUT = 65535
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  tx_dma_chan_ctrl_if.slave           mi,
  input  logic                        PKT_ACC_VLD,
  input  logic [$clog2(CHANNELS)-1:0] PKT_ACC_CHAN,
  input  logic                        PKT_DONE_VLD,
  input  logic [$clog2(CHANNELS)-1:0] PKT_DONE_CHAN,
  output logic [CHANNELS-1:0]         CHAN_ENABLE,
  output logic [CHANNELS-1:0]         CHAN_ACTIVE
);
  localparam int CW = $clog2(CHANNELS);
  logic [CW-1:0]       ch;
  logic [3:0]          off;
  logic                wr_ok;
  logic [MI_WIDTH-1:0] ctrl_a [CHANNELS];
  logic [MI_WIDTH-1:0] status_a [CHANNELS];
  logic [MI_WIDTH-1:0] pend_a [CHANNELS];
  logic [MI_WIDTH-1:0] drops_a [CHANNELS];
  logic [MI_WIDTH-1:0] rd_data, drd_q;
  logic                drdy_q;
  logic                unused;
  assign ch     = mi.MI_ADDR[CW+3:4];
  assign off    = mi.MI_ADDR[3:0];
  assign wr_ok  = mi.MI_WR && mi.MI_BE[0];
  assign unused = ^{mi.MI_ADDR[MI_WIDTH-1:CW+4], mi.MI_DWR[MI_WIDTH-1:1], mi.MI_BE[MI_WIDTH/8-1:1]};
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    chan_state_t            st;
    logic                   ctrl, tout, unf;
    logic [PEND_WIDTH-1:0]  pend;
    logic [CNTRS_WIDTH-1:0] drops;
    tx_dma_chan_ctrl_fsm #(
      .PEND_WIDTH  (PEND_WIDTH),
      .CNTRS_WIDTH (CNTRS_WIDTH),
      .STOP_TIMEOUT(STOP_TIMEOUT)
    ) u_fsm (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .ctrl_wr_i  (wr_ok && off == REG_CONTROL && ch == CW'(i)),
      .wr_bit_i   (mi.MI_DWR[0]),
      .drops_clr_i(wr_ok && off == REG_DROPS && ch == CW'(i)),
      .acc_i      (PKT_ACC_VLD && PKT_ACC_CHAN == CW'(i)),
      .done_i     (PKT_DONE_VLD && PKT_DONE_CHAN == CW'(i)),
      .state_o    (st),
      .ctrl_o     (ctrl),
      .tout_o     (tout),
      .unf_o      (unf),
      .pend_o     (pend),
      .drops_o    (drops)
    );
    assign CHAN_ENABLE[i] = st == ST_RUNNING;
    assign CHAN_ACTIVE[i] = st != ST_STOPPED;
    assign ctrl_a[i]      = MI_WIDTH'(ctrl);
    assign status_a[i]    = (MI_WIDTH'(st) << ST_STATE_LSB) | (MI_WIDTH'(tout) << ST_TOUT_BIT) |
                            (MI_WIDTH'(unf) << ST_UNF_BIT);
    assign pend_a[i]      = MI_WIDTH'(pend);
    assign drops_a[i]     = MI_WIDTH'(drops);
  end
  // register read mux; unmapped offsets return zero
  always_comb
    rd_data = off == REG_CONTROL ? ctrl_a[ch] :
              off == REG_STATUS  ? status_a[ch] :
              off == REG_PENDING ? pend_a[ch] :
              off == REG_DROPS   ? drops_a[ch] : '0;
  // read data is registered so it reflects state before any same-cycle update
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      drd_q  <= '0;
      drdy_q <= 1'b0;
    end else begin
      drdy_q <= mi.MI_RD;
      drd_q  <= mi.MI_RD ? rd_data : '0;
    end
  assign mi.MI_DRD  = drd_q;
  assign mi.MI_DRDY = drdy_q;
  assign mi.MI_ARDY = 1'b1;
endmodule
